// File: rtl/sd_sinc_filter_if.sv
// Bitstream, configuration and read-handshake bundle between the input control
// unit / register stage (master) and the sinc decimation filter (slave).
interface sd_sinc_filter_if #(
    parameter int ACC_W = 25
);
    logic             sd_dsd_in;
    logic             sd_clk_in;
    logic             reg_en;
    logic [1:0]       reg_ftype;
    logic [7:0]       reg_osr;
    logic             rd_ack;
    logic [ACC_W-1:0] data_out;
    logic             data_ready;
    logic             data_pend;
    logic             data_ovr;

    modport master (
        output sd_dsd_in, sd_clk_in, reg_en, reg_ftype, reg_osr, rd_ack,
        input  data_out, data_ready, data_pend, data_ovr
    );

    modport slave (
        input  sd_dsd_in, sd_clk_in, reg_en, reg_ftype, reg_osr, rd_ack,
        output data_out, data_ready, data_pend, data_ovr
    );
endinterface

// File: rtl/sd_sinc_filter.sv
// Decimating sinc1/2/3 (CIC) filter: bit strobe detect, three integrators, decimation
// counter, comb cascade with start-up settling, and a pending/overrun read handshake.
module sd_sinc_filter #(
    parameter int ACC_W = 25
) (
    input logic             SYSCLK,
    input logic             SYSRST,
    sd_sinc_filter_if.slave bus
);
    typedef logic [ACC_W-1:0] acc_t;

    logic       clk_prev_q, clk_prev_d;
    logic [1:0] ftype_q, ftype_d;
    logic [7:0] osr_q, osr_d;
    logic [7:0] dec_cnt_q, dec_cnt_d;
    logic       dec_evt_q, dec_evt_d;
    logic [1:0] settle_q, settle_d;
    acc_t       integ1_q, integ1_d, integ2_q, integ2_d, integ3_q, integ3_d;
    acc_t       dly1_q, dly1_d, dly2_q, dly2_d, dly3_q, dly3_d;
    acc_t       data_out_q, data_out_d;
    logic       data_ready_q, data_ready_d;
    logic       data_pend_q, data_pend_d;
    logic       data_ovr_q, data_ovr_d;

    logic       strobe_s, restart_s;
    logic [1:0] settle_max_s;
    acc_t       bit_s, comb_in_s, diff1_s, diff2_s, diff3_s, result_s;

    // Strobe/restart detection and order-dependent tap of the integrator/comb chain.
    always_comb begin
        strobe_s  = bus.sd_clk_in & ~clk_prev_q & bus.reg_en;
        restart_s = ~bus.reg_en | (bus.reg_ftype != ftype_q) | (bus.reg_osr != osr_q);
        bit_s     = {{(ACC_W-1){1'b0}}, bus.sd_dsd_in};
        case (ftype_q)
            2'b00:   begin settle_max_s = 2'd0; comb_in_s = integ1_q; end
            2'b01:   begin settle_max_s = 2'd1; comb_in_s = integ2_q; end
            default: begin settle_max_s = 2'd2; comb_in_s = integ3_q; end
        endcase
        diff1_s = comb_in_s - dly1_q;
        diff2_s = diff1_s - dly2_q;
        diff3_s = diff2_s - dly3_q;
        case (ftype_q)
            2'b00:   result_s = diff1_s;
            2'b01:   result_s = diff2_s;
            default: result_s = diff3_s;
        endcase
    end

    // Filter datapath next state; a restart wipes all history but leaves the last word.
    always_comb begin
        clk_prev_d   = bus.sd_clk_in;
        ftype_d      = bus.reg_ftype;
        osr_d        = bus.reg_osr;
        integ1_d     = integ1_q;
        integ2_d     = integ2_q;
        integ3_d     = integ3_q;
        dec_cnt_d    = dec_cnt_q;
        dec_evt_d    = 1'b0;
        settle_d     = settle_q;
        dly1_d       = dly1_q;
        dly2_d       = dly2_q;
        dly3_d       = dly3_q;
        data_out_d   = data_out_q;
        data_ready_d = 1'b0;
        if (restart_s) begin
            integ1_d  = '0;
            integ2_d  = '0;
            integ3_d  = '0;
            dec_cnt_d = 8'd0;
            settle_d  = 2'd0;
            dly1_d    = '0;
            dly2_d    = '0;
            dly3_d    = '0;
        end else begin
            if (strobe_s) begin
                // Each stage accumulates the freshly updated value of the stage before it.
                integ1_d = integ1_q + bit_s;
                integ2_d = integ2_q + integ1_d;
                integ3_d = integ3_q + integ2_d;
                if (dec_cnt_q == osr_q) begin
                    dec_cnt_d = 8'd0;
                    dec_evt_d = 1'b1;
                end else begin
                    dec_cnt_d = dec_cnt_q + 8'd1;
                end
            end else begin
                dec_evt_d = 1'b0;
            end
            if (dec_evt_q) begin
                dly1_d = comb_in_s;
                dly2_d = diff1_s;
                dly3_d = diff2_s;
                if (settle_q == settle_max_s) begin
                    data_out_d   = result_s;
                    data_ready_d = 1'b1;
                end else begin
                    settle_d = settle_q + 2'd1;
                end
            end else begin
                data_ready_d = 1'b0;
            end
        end
    end

    // Read handshake: a coincident rd_ack cannot cancel a new word but does clear overrun.
    always_comb begin
        if (data_ready_q) begin
            data_pend_d = 1'b1;
        end else if (bus.rd_ack) begin
            data_pend_d = 1'b0;
        end else begin
            data_pend_d = data_pend_q;
        end
        if (bus.rd_ack) begin
            data_ovr_d = 1'b0;
        end else if (data_ready_q & data_pend_q) begin
            data_ovr_d = 1'b1;
        end else begin
            data_ovr_d = data_ovr_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge SYSCLK) begin
        if (SYSRST) begin
            clk_prev_q   <= 1'b0;
            ftype_q      <= 2'd0;
            osr_q        <= 8'd0;
            dec_cnt_q    <= 8'd0;
            dec_evt_q    <= 1'b0;
            settle_q     <= 2'd0;
            integ1_q     <= '0;
            integ2_q     <= '0;
            integ3_q     <= '0;
            dly1_q       <= '0;
            dly2_q       <= '0;
            dly3_q       <= '0;
            data_out_q   <= '0;
            data_ready_q <= 1'b0;
            data_pend_q  <= 1'b0;
            data_ovr_q   <= 1'b0;
        end else begin
            clk_prev_q   <= clk_prev_d;
            ftype_q      <= ftype_d;
            osr_q        <= osr_d;
            dec_cnt_q    <= dec_cnt_d;
            dec_evt_q    <= dec_evt_d;
            settle_q     <= settle_d;
            integ1_q     <= integ1_d;
            integ2_q     <= integ2_d;
            integ3_q     <= integ3_d;
            dly1_q       <= dly1_d;
            dly2_q       <= dly2_d;
            dly3_q       <= dly3_d;
            data_out_q   <= data_out_d;
            data_ready_q <= data_ready_d;
            data_pend_q  <= data_pend_d;
            data_ovr_q   <= data_ovr_d;
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.data_ready = data_ready_q;
    assign bus.data_pend  = data_pend_q;
    assign bus.data_ovr   = data_ovr_q;
endmodule

// File: tb/tb_sd_sinc_filter.sv
// Bench for sd_sinc_filter: directed scenarios with literal expectations plus random
// traffic, all checked every cycle against a window/kernel-convolution reference model.
module tb_sd_sinc_filter;
    localparam int ACC_W = 25;

    logic SYSCLK = 1'b0;
    logic SYSRST;
    always #5 SYSCLK = ~SYSCLK;

    sd_sinc_filter_if #(.ACC_W(ACC_W)) bus ();
    sd_sinc_filter #(.ACC_W(ACC_W)) dut (.SYSCLK(SYSCLK), .SYSRST(SYSRST), .bus(bus));

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;
    bit ack_rand = 1'b0;

    // Reference model state: the raw bit history since the last restart.
    bit         m_bits[$];
    int         m_nstrobe, m_period;
    bit         m_s1_valid;
    longint     m_s1_val;
    bit         m_ready, m_pend, m_ovr;
    longint     m_out;
    bit         m_clk_prev;
    logic [1:0] m_ft_prev;
    logic [7:0] m_osr_prev;
    longint     h[0:767];
    int         h_len = 0;
    int         h_r = -1;
    int         h_n = -1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int order_of(input logic [1:0] ft);
        return (ft == 2'd0) ? 1 : ((ft == 2'd1) ? 2 : 3);
    endfunction

    // sinc^N kernel = N-fold convolution of a length-R boxcar.
    function automatic void build_kernel(input int r, input int n);
        longint tmp[0:767];
        int len;
        len = r;
        for (int k = 0; k < 768; k++) h[k] = (k < r) ? 64'd1 : 64'd0;
        for (int s = 1; s < n; s++) begin
            for (int k = 0; k < 768; k++) tmp[k] = 0;
            for (int k = 0; k < len; k++)
                for (int j = 0; j < r; j++) tmp[k + j] += h[k];
            len += r - 1;
            for (int k = 0; k < 768; k++) h[k] = tmp[k];
        end
        h_len = len;
        h_r   = r;
        h_n   = n;
    endfunction

    function automatic longint window_sum(input int r, input int n);
        longint acc;
        int sz;
        acc = 0;
        if (r != h_r || n != h_n) build_kernel(r, n);
        sz = m_bits.size();
        for (int k = 0; k < h_len; k++)
            if (sz - 1 - k >= 0 && m_bits[sz - 1 - k]) acc += h[k];
        return acc & ((64'd1 << ACC_W) - 64'd1);
    endfunction

    // Model update at each active edge, then per-cycle comparison of all outputs.
    always @(posedge SYSCLK) begin
        bit clk_i, dsd_i, en_i, ack_i, rst_i, restart, strobe, new_ready;
        logic [1:0] ft_i;
        logic [7:0] osr_i;
        int r, n;
        clk_i = bus.sd_clk_in; dsd_i = bus.sd_dsd_in; en_i = bus.reg_en;
        ack_i = bus.rd_ack;    rst_i = SYSRST;        ft_i = bus.reg_ftype;
        osr_i = bus.reg_osr;
        if (rst_i) begin
            m_bits.delete();
            m_nstrobe = 0; m_period = 0; m_s1_valid = 0; m_s1_val = 0;
            m_ready = 0; m_pend = 0; m_ovr = 0; m_out = 0;
            m_clk_prev = 0; m_ft_prev = 2'd0; m_osr_prev = 8'd0;
        end else begin
            restart   = !en_i || (ft_i != m_ft_prev) || (osr_i != m_osr_prev);
            strobe    = clk_i && !m_clk_prev && en_i;
            new_ready = m_s1_valid && !restart;
            if (ack_i) m_ovr = 0;
            else if (m_ready && m_pend) m_ovr = 1;
            if (m_ready) m_pend = 1;
            else if (ack_i) m_pend = 0;
            if (new_ready) m_out = m_s1_val;
            m_s1_valid = 0;
            if (restart) begin
                m_bits.delete();
                m_nstrobe = 0;
                m_period  = 0;
            end else if (strobe) begin
                m_bits.push_back(dsd_i);
                if (m_bits.size() > 800) void'(m_bits.pop_front());
                m_nstrobe++;
                r = int'(osr_i) + 1;
                n = order_of(ft_i);
                if (m_nstrobe % r == 0) begin
                    m_period++;
                    if (m_period >= n) begin
                        m_s1_valid = 1;
                        m_s1_val   = window_sum(r, n);
                    end
                end
            end
            m_ready    = new_ready;
            m_clk_prev = clk_i;
            m_ft_prev  = ft_i;
            m_osr_prev = osr_i;
        end
        #1;
        check("data_ready", 64'(bus.data_ready), 64'(m_ready));
        check("data_out",   64'(bus.data_out),   64'(m_out));
        check("data_pend",  64'(bus.data_pend),  64'(m_pend));
        check("data_ovr",   64'(bus.data_ovr),   64'(m_ovr));
        if (bus.data_ready === 1'b1) pulse_cnt++;
    end

    task automatic idle(input int n);
        bus.sd_clk_in = 1'b0;
        bus.rd_ack    = 1'b0;
        repeat (n) @(negedge SYSCLK);
    endtask

    // pat: 0 zeros, 1 ones, 2 alternating 1/0, other random. pulse: 1-cycle strobe vs level clock.
    task automatic run_bits(input int nbits, input int period, input bit pulse,
                            input int pat, input bit ack_rdy);
        for (int b = 0; b < nbits; b++) begin
            case (pat)
                0:       bus.sd_dsd_in = 1'b0;
                1:       bus.sd_dsd_in = 1'b1;
                2:       bus.sd_dsd_in = ~b[0];
                default: bus.sd_dsd_in = 1'($urandom_range(0, 1));
            endcase
            for (int c = 0; c < period; c++) begin
                bus.sd_clk_in = pulse ? (c == 0) : (c < period / 2);
                bus.rd_ack = (ack_rdy && bus.data_ready) ||
                             (ack_rand && ($urandom_range(0, 7) == 0));
                @(negedge SYSCLK);
            end
        end
        bus.rd_ack = 1'b0;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_out"},   64'(bus.data_out),   64'd0);
        check({tag, "_ready"}, 64'(bus.data_ready), 64'd0);
        check({tag, "_pend"},  64'(bus.data_pend),  64'd0);
        check({tag, "_ovr"},   64'(bus.data_ovr),   64'd0);
    endtask

    initial begin
        SYSRST = 1'b1;
        bus.sd_dsd_in = 1'b0; bus.sd_clk_in = 1'b0; bus.reg_en = 1'b0;
        bus.reg_ftype = 2'd0; bus.reg_osr = 8'd0;   bus.rd_ack = 1'b0;
        repeat (3) @(negedge SYSCLK);
        reset_checks("reset");
        SYSRST = 1'b0;

        // sinc1, R=16, all ones, level clock period 4.
        bus.reg_en = 1'b1; bus.reg_ftype = 2'd0; bus.reg_osr = 8'd15;
        idle(3);
        run_bits(15, 4, 1'b0, 1, 1'b0);
        bus.sd_dsd_in = 1'b1; bus.sd_clk_in = 1'b1;
        @(negedge SYSCLK);
        check("sinc1_lat1_ready", 64'(bus.data_ready), 64'd0);
        @(negedge SYSCLK);
        check("sinc1_lat2_ready", 64'(bus.data_ready), 64'd1);
        check("sinc1_out", 64'(bus.data_out), 64'd16);
        check("model_sinc1", 64'(m_out), 64'd16);
        idle(2);
        pulse_cnt = 0;
        run_bits(64, 4, 1'b0, 1, 1'b0);
        check("sinc1_pulses", 64'(pulse_cnt), 64'd4);
        check("sinc1_ovr", 64'(bus.data_ovr), 64'd1);

        // Handshake: clear, two unread results, then ack coincident with the third.
        bus.rd_ack = 1'b1;
        @(negedge SYSCLK);
        bus.rd_ack = 1'b0;
        check("ack_pend", 64'(bus.data_pend), 64'd0);
        check("ack_ovr",  64'(bus.data_ovr),  64'd0);
        run_bits(16, 4, 1'b0, 1, 1'b0);
        check("hs1_pend", 64'(bus.data_pend), 64'd1);
        check("hs1_ovr",  64'(bus.data_ovr),  64'd0);
        run_bits(16, 4, 1'b0, 1, 1'b0);
        check("hs2_ovr",  64'(bus.data_ovr),  64'd1);
        run_bits(16, 4, 1'b0, 1, 1'b1);
        check("hs3_pend", 64'(bus.data_pend), 64'd1);
        check("hs3_ovr",  64'(bus.data_ovr),  64'd0);

        // sinc3, R=16: two suppressed results, then 16^3; zeros flush to 0.
        bus.reg_ftype = 2'd2;
        idle(2);
        pulse_cnt = 0;
        run_bits(32, 4, 1'b1, 1, 1'b0);
        check("sinc3_suppressed", 64'(pulse_cnt), 64'd0);
        run_bits(16, 4, 1'b1, 1, 1'b0);
        check("sinc3_first", 64'(pulse_cnt), 64'd1);
        check("sinc3_out", 64'(bus.data_out), 64'd4096);
        check("model_sinc3", 64'(m_out), 64'd4096);
        run_bits(48, 4, 1'b1, 0, 1'b0);
        check("sinc3_zero", 64'(bus.data_out), 64'd0);

        // sinc2, R=4, alternating bits with 1-cycle pulse clock.
        bus.reg_ftype = 2'd1; bus.reg_osr = 8'd3;
        idle(2);
        run_bits(40, 4, 1'b1, 2, 1'b0);
        check("sinc2_alt", 64'(bus.data_out), 64'd8);
        check("model_sinc2", 64'(m_out), 64'd8);

        // sinc3 at R=256: full-scale word without wrap.
        bus.reg_ftype = 2'd2; bus.reg_osr = 8'd255;
        idle(2);
        pulse_cnt = 0;
        run_bits(768, 2, 1'b1, 1, 1'b0);
        check("sinc3_fs_pulses", 64'(pulse_cnt), 64'd1);
        check("sinc3_fs", 64'(bus.data_out), 64'h1000000);
        check("model_fs", 64'(m_out), 64'h1000000);

        // OSR change mid-period restarts settling.
        bus.reg_osr = 8'd7;
        idle(2);
        run_bits(12, 4, 1'b1, 1, 1'b0);
        bus.reg_osr = 8'd5;
        idle(2);
        pulse_cnt = 0;
        run_bits(17, 4, 1'b1, 1, 1'b0);
        check("osr_chg_quiet", 64'(pulse_cnt), 64'd0);
        run_bits(1, 4, 1'b1, 1, 1'b0);
        check("osr_chg_first", 64'(pulse_cnt), 64'd1);
        check("osr_chg_out", 64'(bus.data_out), 64'd216);

        // Reset mid-period.
        run_bits(9, 4, 1'b1, 1, 1'b0);
        SYSRST = 1'b1;
        repeat (2) @(negedge SYSCLK);
        reset_checks("midrst");
        SYSRST = 1'b0;
        idle(2);
        pulse_cnt = 0;
        run_bits(17, 4, 1'b1, 1, 1'b0);
        check("rst_quiet", 64'(pulse_cnt), 64'd0);
        run_bits(1, 4, 1'b1, 1, 1'b0);
        check("rst_first_out", 64'(bus.data_out), 64'd216);

        // Random traffic: configuration changes, enable drops, resets, random acks.
        for (int it = 0; it < 24; it++) begin
            bus.reg_ftype = 2'($urandom_range(0, 3));
            bus.reg_osr   = 8'($urandom_range(0, 23));
            bus.reg_en    = ($urandom_range(0, 5) != 0);
            ack_rand      = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) begin
                SYSRST = 1'b1;
                repeat (2) @(negedge SYSCLK);
                SYSRST = 1'b0;
            end
            run_bits($urandom_range(10, 90), $urandom_range(2, 5),
                     1'($urandom_range(0, 1)), 3, 1'b0);
        end
        ack_rand = 1'b0;
        idle(4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
